// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register for the 5-stage MIPS core.
// Carries PC, write-back control, destination register, T_new and an opaque payload.
// Adds stall/hold, flush (bubble insertion), a valid bit, optional T_new countdown
// and a forwarding qualifier decoded from registered state.
// Optional feature macro: PIPE_STAGE_REG_PERF_EN (bubble/stall performance counters).
module pipe_stage_reg #(
  parameter int PAYLOAD_W         = 96,
  parameter int TNEW_W            = 2,
  parameter int TNEW_DEC          = 1,
  parameter int TNEW_DEC_ON_STALL = 0,
  parameter int FLUSH_KEEP_PC     = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall_in,
  input  logic                 flush_in,
  input  logic                 valid_in,
  input  logic [31:0]          PC_in,
  input  logic [TNEW_W-1:0]    T_new_in,
  input  logic                 RegWrite_in,
  input  logic [4:0]           A3_in,
  input  logic [PAYLOAD_W-1:0] payload_in,
  output logic                 valid_out,
  output logic [31:0]          PC_out,
  output logic [TNEW_W-1:0]    T_new_out,
  output logic                 RegWrite_out,
  output logic [4:0]           A3_out,
  output logic [PAYLOAD_W-1:0] payload_out,
  output logic                 fwd_ok_out
`ifdef PIPE_STAGE_REG_PERF_EN
  ,
  output logic [31:0]          bubble_cnt_out,
  output logic [31:0]          stall_cnt_out
`endif
);

  logic                 r_valid;
  logic [31:0]          r_pc;
  logic [TNEW_W-1:0]    r_tnew;
  logic                 r_regwrite;
  logic [4:0]           r_a3;
  logic [PAYLOAD_W-1:0] r_payload;

  logic [TNEW_W-1:0]    w_tnew_in_dec;
  logic [TNEW_W-1:0]    w_tnew_out_dec;
  logic [TNEW_W-1:0]    w_tnew_load;
  logic                 w_regwrite_load;
  logic                 w_valid_next;

  // Saturating decrements: T_new never wraps below zero.
  assign w_tnew_in_dec   = (T_new_in == '0) ? '0 : T_new_in - TNEW_W'(1);
  assign w_tnew_out_dec  = (r_tnew == '0) ? '0 : r_tnew - TNEW_W'(1);
  assign w_tnew_load     = (TNEW_DEC != 0) ? w_tnew_in_dec : T_new_in;
  // Writes to $0 and from bubbles must never reach the register file.
  assign w_regwrite_load = RegWrite_in & valid_in & (A3_in != 5'd0);
  // Value valid_out will hold after this edge (used by the perf counters).
  assign w_valid_next    = flush_in ? 1'b0 : (stall_in ? r_valid : valid_in);

  // Stage register: reset > flush > stall > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_tnew     <= '0;
      r_regwrite <= 1'b0;
      r_a3       <= '0;
      r_payload  <= '0;
    end else if (flush_in) begin
      r_valid    <= 1'b0;
      r_pc       <= (FLUSH_KEEP_PC != 0) ? PC_in : 32'd0;
      r_tnew     <= '0;
      r_regwrite <= 1'b0;
      r_a3       <= '0;
      r_payload  <= '0;
    end else if (stall_in) begin
      if (TNEW_DEC_ON_STALL != 0) begin
        r_tnew <= w_tnew_out_dec;
      end
    end else begin
      r_valid    <= valid_in;
      r_pc       <= PC_in;
      r_tnew     <= w_tnew_load;
      r_regwrite <= w_regwrite_load;
      r_a3       <= valid_in ? A3_in : 5'd0;
      r_payload  <= payload_in;
    end
  end

  assign valid_out    = r_valid;
  assign PC_out       = r_pc;
  assign T_new_out    = r_tnew;
  assign RegWrite_out = r_regwrite;
  assign A3_out       = r_a3;
  assign payload_out  = r_payload;
  // Forwarding allowed only from a real, writing, non-$0 instruction whose result is ready.
  assign fwd_ok_out   = r_valid & r_regwrite & (r_a3 != 5'd0) & (r_tnew == '0);

`ifdef PIPE_STAGE_REG_PERF_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_stall_cnt;

  // Saturating counters of bubble-holding edges and true stall edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bubble_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (!w_valid_next && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
      if (stall_in && !flush_in && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign bubble_cnt_out = r_bubble_cnt;
  assign stall_cnt_out  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg.
// Two instances share the stimulus: dut_a uses the default parameters,
// dut_b uses TNEW_DEC=0, TNEW_DEC_ON_STALL=1, FLUSH_KEEP_PC=1.
// When PIPE_STAGE_REG_PERF_EN is defined the perf counters are checked as well.
module tb_pipe_stage_reg;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [1:0]  tnew;
    logic        rw;
    logic [4:0]  a3;
    logic [95:0] payload;
    logic        fwd;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        stall_in;
  logic        flush_in;
  logic        valid_in;
  logic [31:0] PC_in;
  logic [1:0]  T_new_in;
  logic        RegWrite_in;
  logic [4:0]  A3_in;
  logic [95:0] payload_in;

  logic        a_valid, b_valid;
  logic [31:0] a_pc, b_pc;
  logic [1:0]  a_tnew, b_tnew;
  logic        a_rw, b_rw;
  logic [4:0]  a_a3, b_a3;
  logic [95:0] a_payload, b_payload;
  logic        a_fwd, b_fwd;
`ifdef PIPE_STAGE_REG_PERF_EN
  logic [31:0] a_bub, a_stl, b_bub, b_stl;
`endif

  int n_checks;
  int n_fail;
  int n_txn;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t st_a;
  exp_t st_b;
  int   m_bub;
  int   m_stl;

  pipe_stage_reg #(
    .PAYLOAD_W(96), .TNEW_W(2), .TNEW_DEC(1), .TNEW_DEC_ON_STALL(0), .FLUSH_KEEP_PC(0)
  ) dut_a (
    .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .PC_in(PC_in), .T_new_in(T_new_in),
    .RegWrite_in(RegWrite_in), .A3_in(A3_in), .payload_in(payload_in),
    .valid_out(a_valid), .PC_out(a_pc), .T_new_out(a_tnew),
    .RegWrite_out(a_rw), .A3_out(a_a3), .payload_out(a_payload),
    .fwd_ok_out(a_fwd)
`ifdef PIPE_STAGE_REG_PERF_EN
    , .bubble_cnt_out(a_bub), .stall_cnt_out(a_stl)
`endif
  );

  pipe_stage_reg #(
    .PAYLOAD_W(96), .TNEW_W(2), .TNEW_DEC(0), .TNEW_DEC_ON_STALL(1), .FLUSH_KEEP_PC(1)
  ) dut_b (
    .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .PC_in(PC_in), .T_new_in(T_new_in),
    .RegWrite_in(RegWrite_in), .A3_in(A3_in), .payload_in(payload_in),
    .valid_out(b_valid), .PC_out(b_pc), .T_new_out(b_tnew),
    .RegWrite_out(b_rw), .A3_out(b_a3), .payload_out(b_payload),
    .fwd_ok_out(b_fwd)
`ifdef PIPE_STAGE_REG_PERF_EN
    , .bubble_cnt_out(b_bub), .stall_cnt_out(b_stl)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (txn %0d)", tag, got, exp, n_txn);
    end
  endtask

  // Reference behaviour of one stage register for one clock edge.
  function automatic exp_t model_next(input exp_t cur, input logic rst, input logic st,
                                      input logic fl, input logic v, input logic [31:0] pc,
                                      input logic [1:0] tn, input logic rw, input logic [4:0] a3,
                                      input logic [95:0] pl, input bit dec, input bit dec_stall,
                                      input bit keep_pc);
    exp_t n;
    n = cur;
    if (rst) begin
      n.valid = 0; n.pc = 0; n.tnew = 0; n.rw = 0; n.a3 = 0; n.payload = 0;
    end else if (fl) begin
      n.valid = 0; n.tnew = 0; n.rw = 0; n.a3 = 0; n.payload = 0;
      n.pc = keep_pc ? pc : 32'd0;
    end else if (st) begin
      if (dec_stall && cur.tnew != 2'd0) n.tnew = cur.tnew - 2'd1;
    end else begin
      n.valid   = v;
      n.pc      = pc;
      n.tnew    = (dec && tn != 2'd0) ? tn - 2'd1 : tn;
      n.rw      = rw & v & (a3 != 5'd0);
      n.a3      = v ? a3 : 5'd0;
      n.payload = pl;
    end
    n.fwd = n.valid & n.rw & (n.a3 != 5'd0) & (n.tnew == 2'd0);
    return n;
  endfunction

  task automatic compare(input string who, input exp_t e, input logic v, input logic [31:0] pc,
                         input logic [1:0] tn, input logic rw, input logic [4:0] a3,
                         input logic [95:0] pl, input logic fwd);
    check_val({who, ".valid"},   128'(v),   128'(e.valid));
    check_val({who, ".pc"},      128'(pc),  128'(e.pc));
    check_val({who, ".tnew"},    128'(tn),  128'(e.tnew));
    check_val({who, ".regwr"},   128'(rw),  128'(e.rw));
    check_val({who, ".a3"},      128'(a3),  128'(e.a3));
    check_val({who, ".payload"}, 128'(pl),  128'(e.payload));
    check_val({who, ".fwd_ok"},  128'(fwd), 128'(e.fwd));
  endtask

  // Drive one transaction, push expectations, clock, then pop and compare.
  task automatic cycle(input logic rst, input logic st, input logic fl, input logic v,
                       input logic [31:0] pc, input logic [1:0] tn, input logic rw,
                       input logic [4:0] a3, input logic [95:0] pl);
    exp_t ea, eb;
    reset = rst; stall_in = st; flush_in = fl; valid_in = v;
    PC_in = pc; T_new_in = tn; RegWrite_in = rw; A3_in = a3; payload_in = pl;
    st_a = model_next(st_a, rst, st, fl, v, pc, tn, rw, a3, pl, 1'b1, 1'b0, 1'b0);
    st_b = model_next(st_b, rst, st, fl, v, pc, tn, rw, a3, pl, 1'b0, 1'b1, 1'b1);
    q_a.push_back(st_a);
    q_b.push_back(st_b);
    if (rst) begin
      m_bub = 0; m_stl = 0;
    end else begin
      if (!st_a.valid) m_bub++;
      if (st && !fl) m_stl++;
    end
    @(posedge clk);
    #1;
    n_txn++;
    $display("txn %0d rst=%0b st=%0b fl=%0b v=%0b pc=%08h tn=%0d rw=%0b a3=%0d | a:tn=%0d fwd=%0b b:pc=%08h tn=%0d",
             n_txn, rst, st, fl, v, pc, tn, rw, a3, a_tnew, a_fwd, b_pc, b_tnew);
    if (q_a.size() == 0 || q_b.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard: queue empty, got 0 entries expected 1");
    end else begin
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      compare("a", ea, a_valid, a_pc, a_tnew, a_rw, a_a3, a_payload, a_fwd);
      compare("b", eb, b_valid, b_pc, b_tnew, b_rw, b_a3, b_payload, b_fwd);
    end
`ifdef PIPE_STAGE_REG_PERF_EN
    check_val("a.bubble_cnt", 128'(a_bub), 128'(m_bub));
    check_val("a.stall_cnt",  128'(a_stl), 128'(m_stl));
    check_val("b.bubble_cnt", 128'(b_bub), 128'(m_bub));
    check_val("b.stall_cnt",  128'(b_stl), 128'(m_stl));
`endif
  endtask

  initial begin
    n_checks = 0; n_fail = 0; n_txn = 0; m_bub = 0; m_stl = 0;
    st_a = '{valid: 0, pc: 0, tnew: 0, rw: 0, a3: 0, payload: 0, fwd: 0};
    st_b = st_a;
    reset = 1'b1; stall_in = 0; flush_in = 0; valid_in = 0; PC_in = 0;
    T_new_in = 0; RegWrite_in = 0; A3_in = 0; payload_in = 0;
    @(negedge clk);

    // Reset with every input nonzero, two edges.
    cycle(1, 1, 1, 1, 32'hDEAD_BEEF, 2'd3, 1, 5'd31, {3{32'hFFFF_FFFF}});
    cycle(1, 1, 1, 1, 32'hDEAD_BEEF, 2'd3, 1, 5'd31, {3{32'hFFFF_FFFF}});
    // First load: forwardable result.
    cycle(0, 0, 0, 1, 32'h3000, 2'd0, 1, 5'd5, 96'h11);
    // T_new countdown and saturation.
    cycle(0, 0, 0, 1, 32'h3004, 2'd2, 1, 5'd6, 96'h22);
    cycle(0, 0, 0, 1, 32'h3008, 2'd0, 1, 5'd6, 96'h33);
    cycle(0, 0, 0, 1, 32'h300C, 2'd3, 1, 5'd8, 96'h44);
    // Stall hold with changing inputs; dut_b counts 2 -> 1, 0, 0.
    cycle(0, 0, 0, 1, 32'h3008, 2'd2, 1, 5'd9, 96'hABCD);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 1, $urandom, 2'($urandom), 1, 5'($urandom_range(1, 31)), {$urandom, $urandom, $urandom});
    end
    // Stall and flush together: flush wins.
    cycle(0, 1, 1, 1, 32'h3010, 2'd1, 1, 5'd3, 96'h55);
    // $0 and invalid-slot suppression.
    cycle(0, 0, 0, 1, 32'h3014, 2'd0, 1, 5'd0, 96'h66);
    cycle(0, 0, 0, 0, 32'h3018, 2'd0, 1, 5'd7, 96'h77);
    // Randomised traffic.
    for (int i = 0; i < 30; i++) begin
      cycle(0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), 1'($urandom),
            $urandom, 2'($urandom), 1'($urandom), 5'($urandom), {$urandom, $urandom, $urandom});
    end
    // Reset asserted mid-stall.
    cycle(1, 1, 0, 1, 32'h4000, 2'd1, 1, 5'd4, 96'h88);
    // Perf sequence: 4 stalls, 2 flushes, 1 stall+flush.
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 1, 32'h5000, 2'd1, 1, 5'd2, 96'h99);
    for (int i = 0; i < 2; i++) cycle(0, 0, 1, 1, 32'h5004, 2'd1, 1, 5'd2, 96'h99);
    cycle(0, 1, 1, 1, 32'h5008, 2'd1, 1, 5'd2, 96'h99);
`ifdef PIPE_STAGE_REG_PERF_EN
    check_val("perf.stall_total", 128'(a_stl), 128'(4));
    check_val("perf.bubble_total", 128'(a_bub), 128'(7));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic inter-stage pipeline register for the 5-stage MIPS core; one instance replaces each hand-written D/E/M/W stage register.
- Carries PC, write-back control, destination register, hazard timer T_new and a parametrised payload bus.
- Adds what fixed stage registers lack: stall/hold, flush (bubble insertion), a valid bit, configurable T_new countdown, and a registered forwarding qualifier.

Parameters:
- PAYLOAD_W, 96, width of opaque payload bus (ALU result, HI/LO, RD2, control fields packed by the instantiating stage).
- TNEW_W, 2, width of T_new.
- TNEW_DEC, 1, 1: T_new decremented (saturating at 0) on load; 0: passed through unchanged.
- TNEW_DEC_ON_STALL, 0, 1: T_new_out keeps decrementing (saturating) while stalled; 0: T_new_out holds.
- FLUSH_KEEP_PC, 0, 1: a flush loads PC_in into PC_out (keeps EPC for the bubble); 0: a flush clears PC_out.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- stall_in  in  1  hold current contents.
- flush_in  in  1  insert bubble.
- valid_in  in  1  incoming instruction is real.
- PC_in  in  32  instruction PC.
- T_new_in  in  TNEW_W  cycles until result ready.
- RegWrite_in  in  1  GRF write enable.
- A3_in  in  5  destination register.
- payload_in  in  PAYLOAD_W  opaque data.
- valid_out  out  1  registered valid.
- PC_out  out  32  registered PC.
- T_new_out  out  TNEW_W  registered T_new.
- RegWrite_out  out  1  qualified write enable.
- A3_out  out  5  registered destination.
- payload_out  out  PAYLOAD_W  registered payload.
- fwd_ok_out  out  1  valid_out & RegWrite_out & (A3_out!=0) & (T_new_out==0); combinational from registers only.

Behaviour:
- All outputs registered except fwd_ok_out (a decode of registered state). Latency is 1 cycle.
- Per-edge priority: reset > flush_in > stall_in > load.
- reset: every register is 0. After reset, valid_out=0, PC_out=0, T_new_out=0, RegWrite_out=0, A3_out=0, payload_out=0, fwd_ok_out=0.
- flush (flush_in=1, any stall_in):
  - valid_out, T_new_out, RegWrite_out, A3_out and payload_out are set to 0.
  - PC_out is set to PC_in if FLUSH_KEEP_PC=1, otherwise 0.
- stall (stall_in=1, flush_in=0):
  - All registers hold.
  - Exception when TNEW_DEC_ON_STALL=1: T_new_out becomes max(T_new_out-1, 0).
- load (stall_in=0, flush_in=0):
  - PC_out, A3_out and payload_out take their inputs; valid_out takes valid_in.
  - T_new_out takes max(T_new_in-1, 0) when TNEW_DEC=1, otherwise T_new_in.
  - RegWrite_out = RegWrite_in & valid_in & (A3_in!=0). Writes to $0 and invalid slots never assert write enable.
  - A3_out is forced to 0 when valid_in=0.
- Saturation: T_new never wraps below 0. A T_new_in of all-ones with TNEW_DEC=1 loads all-ones minus 1.
- Simultaneous stall and flush: the flush wins. Reset asserted mid-stall or mid-flush wins.
- payload is never interpreted, except that it is zeroed on reset and flush.

Optional Feature:
- Macro PIPE_STAGE_REG_PERF_EN.
- Defined:
  - Adds outputs bubble_cnt_out [31:0] and stall_cnt_out [31:0].
  - bubble_cnt_out increments on every non-reset edge that leaves valid_out=0.
  - stall_cnt_out increments on every edge where stall_in=1 and flush_in=0.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: the ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset:
  - Stimulus: drive all inputs to nonzero values, assert reset for 2 edges.
  - Response: all outputs are 0 and fwd_ok_out=0.
  - Then release reset and load PC_in=0x3000, T_new_in=0, RegWrite_in=1, A3_in=5, valid_in=1. Next cycle: PC_out=0x3000, T_new_out=0, RegWrite_out=1, fwd_ok_out=1.
- T_new countdown (TNEW_DEC=1):
  - Load T_new_in=2 and hold the input stream.
  - Response: T_new_out=1 and fwd_ok_out=0. A second load with T_new_in=0 gives T_new_out=0 (saturated, no wrap to 3).
- Stall hold:
  - Load payload 0xABCD, then assert stall_in for 3 cycles while the inputs change.
  - Response: payload_out stays 0xABCD and all fields hold. With TNEW_DEC_ON_STALL=1 and T_new_out=2 held, the sequence is 1, 0, 0.
- Flush priority:
  - Assert stall_in=1 and flush_in=1 with PC_in=0x3010.
  - Response: valid_out=0, RegWrite_out=0, A3_out=0, payload_out=0.
  - PC_out=0x3010 with FLUSH_KEEP_PC=1, or 0 with FLUSH_KEEP_PC=0.
- $0 and invalid suppression:
  - Load A3_in=0 with RegWrite_in=1 and valid_in=1. Response: RegWrite_out=0.
  - Load A3_in=7 with valid_in=0. Response: RegWrite_out=0, A3_out=0, fwd_ok_out=0.
- Perf counters (PIPE_STAGE_REG_PERF_EN):
  - Stimulus: after reset, 4 stall cycles, 2 flush cycles, 1 stall+flush cycle.
  - Response: stall_cnt_out=4. bubble_cnt_out counts every non-reset edge that ends with valid_out=0 (the 3 flush edges plus any stalled edges holding a bubble).
